// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program_loader boot loader.
interface program_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        done;
    logic        error;
    logic [2:0]  state_dbg;

    // Handshake: a byte transfers on a posedge where rx_valid && rx_ready. rx_data is
    // sampled only on a transfer, and rx_valid may stay high for any number of cycles.
    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error, state_dbg
    );
    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error, state_dbg
    );
endinterface

// File: rtl/program_loader.sv
// Length-prefixed byte-serial boot loader writing little-endian words into instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (CHECK state).
module program_loader #(
    parameter int          MAX_WORDS = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    program_loader_if.slave bus
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0, S_LEN_HI = 3'd1, S_DATA = 3'd2, S_WRITE = 3'd3,
        S_CHECK  = 3'd4, S_DONE   = 3'd5, S_ERROR = 3'd6
    } state_t;
    localparam state_t S_TAIL = S_CHECK;
`else
    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0, S_LEN_HI = 3'd1, S_DATA = 3'd2, S_WRITE = 3'd3,
        S_DONE   = 3'd5, S_ERROR  = 3'd6
    } state_t;
    localparam state_t S_TAIL = S_DONE;
`endif

    localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

    state_t      state, state_next;
    logic [15:0] len;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        rx_ready;
    logic        xfer;
    logic [15:0] len_in;
    logic        more_words;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  chk;
`endif

    assign xfer       = bus.rx_valid && rx_ready;
    assign len_in     = {bus.rx_data, len[7:0]};
    assign more_words = ({16'd0, word_idx} + 32'd1) < {16'd0, len};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_LEN_LO;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        case (state)
            S_LEN_LO: begin
                rx_ready = 1'b1;
                if (xfer) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                rx_ready = 1'b1;
                if (xfer) begin
                    if ({16'd0, len_in} > MAX_N) state_next = S_ERROR;
                    else if (len_in == 16'd0)    state_next = S_TAIL;
                    else                         state_next = S_DATA;
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                if (xfer && byte_cnt == 2'd3) state_next = S_WRITE;
            end
            S_WRITE: begin
                state_next = more_words ? S_DATA : S_TAIL;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                rx_ready = 1'b1;
                if (xfer) state_next = (bus.rx_data == chk) ? S_DONE : S_ERROR;
            end
`endif
            default: state_next = state;
        endcase
    end

    // Address/data are captured with the 4th byte so they are stable for the whole WRITE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            len      <= 16'd0;
            word_idx <= 16'd0;
            byte_cnt <= 2'd0;
            shift    <= 24'd0;
            addr_q   <= BASE_ADDR;
            wdata_q  <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            chk      <= 8'd0;
`endif
        end else begin
            case (state)
                S_LEN_LO: begin
`ifdef LOADER_CHECKSUM_EN
                    chk <= 8'd0;
`endif
                    if (xfer) len[7:0] <= bus.rx_data;
                end
                S_LEN_HI: begin
                    if (xfer) len[15:8] <= bus.rx_data;
                end
                S_DATA: begin
                    if (xfer) begin
                        shift    <= {bus.rx_data, shift[23:8]};
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        chk      <= chk ^ bus.rx_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            addr_q  <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                            wdata_q <= {bus.rx_data, shift};
                        end
                    end
                end
                S_WRITE: begin
                    word_idx <= word_idx + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.rx_ready   = rx_ready;
    assign bus.imem_we    = (state == S_WRITE);
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.core_reset = (state != S_DONE);
    assign bus.done       = (state == S_DONE);
    assign bus.error      = (state == S_ERROR);
    assign bus.state_dbg  = state;

endmodule
